reaction_timer_core: RTL and testbench

Self-contained reaction-time tester: owns its own round FSM, pseudo-random delay generator, tick prescaler and BCD timer. It generalises the earlier externally-sequenced reaction datapath to N digits, adds false-start detection, overflow saturation and a best-time register. It sits between debounced pushbutton pulses and the board LEDs and 7-segment displays.

---
 rtl/reaction_pkg.sv | 39 +++
 rtl/reaction_timer_core_if.sv | 32 +++
 rtl/bcd_counter.sv | 48 ++++
 rtl/seg7.sv | 23 ++
 rtl/reaction_timer_core.sv | 157 +++++++++++++++
 tb/tb_reaction_timer_core.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction timer.
// State codes, LED patterns, LFSR seed and step.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_TIMING  = 3'd2,
    S_DISPLAY = 3'd3,
    S_FOUL    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci, taps 16,14,13,11 (right-shift form)
  function automatic logic [15:0] lfsr_next(
    logic [15:0] s
  );
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic led_bit(
    state_e s,
    int     i,
    int     w
  );
    logic b;
    b = 1'b0;
    case (s)
      S_DELAY:   b = (i == w - 1);
      S_TIMING:  b = 1'b1;
      S_DISPLAY: b = ((w - 1 - i) % 2 == 0);
      S_FOUL:    b = (i >= w - w / 2);
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Button pulses in, status/display out.
// master = button side, slave = timer core.
interface reaction_timer_core_if #(
  parameter int N_DIGITS = 2,
  parameter int LED_W    = 10
);
  logic                  start;
  logic                  react;
  logic                  clear_best;
  logic [LED_W-1:0]      led;
  logic [4*N_DIGITS-1:0] bcd;
  logic [7*N_DIGITS-1:0] hex;
  logic [4*N_DIGITS-1:0] best_bcd;
  logic                  best_valid;
  logic                  false_start;
  logic                  overflow;
  logic [2:0]            state_o;

  modport master (
    output start, react, clear_best,
    input  led, bcd, hex, best_bcd,
    input  best_valid, false_start,
    input  overflow, state_o
  );

  modport slave (
    input  start, react, clear_best,
    output led, bcd, hex, best_bcd,
    output best_valid, false_start,
    output overflow, state_o
  );
endinterface

// File: rtl/bcd_counter.sv
// Saturating N-digit BCD counter.
// clr > fill8 > inc; at_max when all digits are 9.
module bcd_counter #(
  parameter int N_DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  clr,
  input  logic                  fill8,
  input  logic                  inc,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  at_max
);
  localparam int BW = 4 * N_DIGITS;

  logic [BW-1:0] bcd_q, bcd_d;
  logic          carry;

  assign at_max = (bcd_q == {N_DIGITS{4'd9}});
  assign bcd    = bcd_q;

  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b0;
    if (clr) begin
      bcd_d = '0;
    end else if (fill8) begin
      bcd_d = {N_DIGITS{4'd8}};
    end else if (inc && !at_max) begin
      carry = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (carry) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) bcd_q <= '0;
    else         bcd_q <= bcd_d;
  end
endmodule

// File: rtl/seg7.sv
// BCD digit to active-high {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module seg7 (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    unique case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time tester: round FSM, LFSR delay, tick, BCD timer.
// Ports: Clock, Resetn, io (start/react/clear_best in; led/bcd/hex/best/status out).
module reaction_timer_core #(
  parameter int N_DIGITS   = 2,
  parameter int LED_W      = 10,
  parameter int TICK_DIV   = 500000,
  parameter int MIN_DELAY  = 100,
  parameter int DELAY_BITS = 9
) (
  input logic            Clock,
  input logic            Resetn,
  reaction_timer_core_if.slave io
);
  import reaction_pkg::*;

  localparam int BW = 4 * N_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(MIN_DELAY + 2**DELAY_BITS) + 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [DW-1:0]    tgt_q, tgt_d;
  logic [BW-1:0]    best_q, best_d;
  logic             bv_q, bv_d;
  logic             fs_q, fs_d;
  logic             ov_q, ov_d;
  logic [LED_W-1:0] led_q, led_d;

  logic          tick;
  logic [DW-1:0] new_tgt;
  logic          cnt_clr, cnt_fill, cnt_inc, cnt_max;
  logic [BW-1:0] cnt_bcd;

  assign tick    = (pre_q == PW'(TICK_DIV - 1));
  assign new_tgt = DW'(MIN_DELAY) + DW'(lfsr_q[DELAY_BITS-1:0]);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dcnt_d   = dcnt_q;
    best_d   = best_q;
    bv_d     = bv_q;
    fs_d     = fs_q;
    ov_d     = ov_q;
    cnt_clr  = 1'b0;
    cnt_fill = 1'b0;
    cnt_inc  = 1'b0;
    lfsr_d   = lfsr_next(lfsr_q);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    case (state_q)
      S_IDLE, S_DISPLAY: begin
        if (io.start) begin
          state_d = S_DELAY;
          tgt_d   = new_tgt;
          dcnt_d  = '0;
        end
      end
      S_DELAY: begin
        if (tick) dcnt_d = dcnt_q + 1'b1;
        // a react on the expiry tick is still a false start
        if (io.react) begin
          state_d  = S_FOUL;
          fs_d     = 1'b1;
          cnt_fill = 1'b1;
        end else if (tick && (dcnt_q + 1'b1) == tgt_q) begin
          state_d = S_TIMING;
          cnt_clr = 1'b1;
          ov_d    = 1'b0;
        end
      end
      S_TIMING: begin
        if (io.react) begin
          state_d = S_DISPLAY;
          if (!ov_q && (!bv_q || cnt_bcd < best_q)) begin
            best_d = cnt_bcd;
            bv_d   = 1'b1;
          end
        end else if (tick) begin
          cnt_inc = 1'b1;
          if (cnt_max) ov_d = 1'b1;
        end
      end
      S_FOUL: begin
        if (io.start) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
          fs_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (io.clear_best) begin
      best_d = {N_DIGITS{4'd9}};
      bv_d   = 1'b0;
    end
    if (state_d != state_q &&
        (state_d == S_DELAY || state_d == S_TIMING)) begin
      pre_d = '0;
    end
    for (int i = 0; i < LED_W; i++) begin
      led_d[i] = led_bit(state_d, i, LED_W);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      dcnt_q  <= '0;
      tgt_q   <= '0;
      best_q  <= {N_DIGITS{4'd9}};
      bv_q    <= 1'b0;
      fs_q    <= 1'b0;
      ov_q    <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      dcnt_q  <= dcnt_d;
      tgt_q   <= tgt_d;
      best_q  <= best_d;
      bv_q    <= bv_d;
      fs_q    <= fs_d;
      ov_q    <= ov_d;
      led_q   <= led_d;
    end
  end

  bcd_counter #(.N_DIGITS(N_DIGITS)) u_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (cnt_clr),
    .fill8  (cnt_fill),
    .inc    (cnt_inc),
    .bcd    (cnt_bcd),
    .at_max (cnt_max)
  );

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_seg
    seg7 u_seg (
      .d   (cnt_bcd[4*g +: 4]),
      .seg (io.hex[7*g +: 7])
    );
  end

  assign io.led         = led_q;
  assign io.bcd         = cnt_bcd;
  assign io.best_bcd    = best_q;
  assign io.best_valid  = bv_q;
  assign io.false_start = fs_q;
  assign io.overflow    = ov_q;
  assign io.state_o     = state_q;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core.
// Expected snapshots queued by stimulus, checked on each output event.
module tb_reaction_timer_core;
  import reaction_pkg::*;

  localparam int ND = 2;
  localparam int LW = 10;
  localparam int TD = 4;
  localparam int MD = 3;
  localparam int DB = 2;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  reaction_timer_core_if #(.N_DIGITS(ND), .LED_W(LW)) io ();

  reaction_timer_core #(
    .N_DIGITS(ND), .LED_W(LW), .TICK_DIV(TD),
    .MIN_DELAY(MD), .DELAY_BITS(DB)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .io     (io)
  );

  typedef struct {
    logic [2:0] st;
    logic [7:0] bcd;
    logic [7:0] best;
    logic       bv;
    logic       fs;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  m_bcd, m_best;
  logic        m_bv, m_ov;
  logic [15:0] m_lfsr;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (!Resetn) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                    m_lfsr[15:1]};
  end

  function automatic logic [7:0] d2(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [6:0] seg(logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;
      4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [9:0] led_of(logic [2:0] st);
    case (st)
      3'd1: return 10'b1000000000;
      3'd2: return 10'b1111111111;
      3'd3: return 10'b1010101010;
      3'd4: return 10'b1111100000;
      default: return 10'b0000000000;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, a, e, cyc);
    end
  endtask

  task automatic push(logic [2:0] st, logic [7:0] b, logic fs, int c);
    exp_t e;
    e.st = st; e.bcd = b; e.best = m_best; e.bv = m_bv;
    e.fs = fs; e.ov = m_ov; e.cyc = c;
    q.push_back(e);
  endtask

  // monitor: an output event is any change of state or status/best
  logic [13:0] prev = '1;
  logic [13:0] trig;
  exp_t me;
  initial forever begin
    @(negedge Clock);
    trig = {io.state_o, io.best_bcd, io.best_valid,
            io.false_start, io.overflow};
    if (trig !== prev) begin
      prev = trig;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: state %0d at cycle %0d",
                 io.state_o, cyc);
      end else begin
        me = q.pop_front();
        if (me.cyc >= 0) chk("event_cycle", cyc, me.cyc);
        chk("state", io.state_o, me.st);
        chk("bcd", io.bcd, me.bcd);
        chk("hex", io.hex, {seg(me.bcd[7:4]), seg(me.bcd[3:0])});
        chk("led", io.led, led_of(me.st));
        chk("best_bcd", io.best_bcd, me.best);
        chk("best_valid", io.best_valid, me.bv);
        chk("false_start", io.false_start, me.fs);
        chk("overflow", io.overflow, me.ov);
      end
    end
  end

  task automatic wait_cyc(int e);
    if (cyc > e) begin
      checks++;
      failures++;
      $display("FAIL schedule: cycle %0d past target %0d", cyc, e);
    end
    while (cyc < e) @(negedge Clock);
  endtask

  task automatic pulse(bit s, bit r, bit c);
    io.start = s; io.react = r; io.clear_best = c;
    @(negedge Clock);
    io.start = 0; io.react = 0; io.clear_best = 0;
  endtask

  task automatic start_delay(output int s, output int t);
    t = MD + int'(m_lfsr[DB-1:0]);
    s = cyc + 1;
    push(S_DELAY, m_bcd, 1'b0, s);
    pulse(1, 0, 0);
  endtask

  // k ticks of timing, react between ticks or on the tick edge
  task automatic round(int k, bit coinc, bit clr);
    int s, t, et, r;
    start_delay(s, t);
    et = s + TD * t;
    m_bcd = 8'h00; m_ov = 1'b0;
    push(S_TIMING, 8'h00, 1'b0, et);
    if (k >= 100) begin
      m_bcd = 8'h99; m_ov = 1'b1;
      push(S_TIMING, 8'h99, 1'b0, et + TD * 100);
    end else begin
      m_bcd = d2(k);
    end
    r = et + TD * k + (coinc ? TD : 2);
    if (!m_ov && (!m_bv || m_bcd < m_best)) begin
      m_best = m_bcd; m_bv = 1'b1;
    end
    if (clr) begin m_best = 8'h99; m_bv = 1'b0; end
    push(S_DISPLAY, m_bcd, 1'b0, r);
    wait_cyc(r - 1);
    pulse(0, 1, clr);
  endtask

  task automatic foul(int off, bit at_exp);
    int s, t, r;
    start_delay(s, t);
    r = at_exp ? s + TD * t : s + off;
    m_bcd = 8'h88;
    push(S_FOUL, 8'h88, 1'b1, r);
    wait_cyc(r - 1);
    pulse(0, 1, 0);
    m_bcd = 8'h00;
    push(S_IDLE, 8'h00, 1'b0, cyc + 1);
    pulse(1, 0, 0);
  endtask

  task automatic clr_only();
    m_best = 8'h99; m_bv = 1'b0;
    push(S_DISPLAY, m_bcd, 1'b0, cyc + 1);
    pulse(0, 0, 1);
  endtask

  task automatic reset_in_timing();
    int s, t, et;
    start_delay(s, t);
    et = s + TD * t;
    m_bcd = 8'h00; m_ov = 1'b0;
    push(S_TIMING, 8'h00, 1'b0, et);
    wait_cyc(et + 21);
    m_best = 8'h99; m_bv = 1'b0;
    push(S_IDLE, 8'h00, 1'b0, et + 22);
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  exp_t left;
  initial begin
    io.start = 0; io.react = 0; io.clear_best = 0;
    Resetn = 1'b0;
    m_bcd = 8'h00; m_best = 8'h99; m_bv = 1'b0; m_ov = 1'b0;
    push(S_IDLE, 8'h00, 1'b0, -1);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    round(12, 0, 0);
    round(7, 0, 0);
    round(20, 0, 0);
    round(7, 0, 0);
    foul(6, 0);
    round(105, 0, 0);
    round(41, 1, 0);
    foul(0, 1);
    round(3, 0, 0);
    round(2, 0, 1);
    round(9, 0, 0);
    clr_only();
    reset_in_timing();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge Clock);
    while (q.size() > 0) begin
      left = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event: state %0d expected at cycle %0d",
               left.st, left.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
